modn_down_timer: RTL
====================

Name: modn_down_timer

Overview:
- Loadable down-counting timer; the count-down counterpart of the team's mod-N up counter.
- A period value is written through a valid/ready load port. The block counts down on enabled ticks and raises a one-cycle expiry pulse after the tick at zero.
- Supports one-shot and auto-reload (periodic) modes.
- Used for pipeline timeouts, watchdogs and periodic event generation in the core.

Parameters:
W, 16, width of count and load value (W >= 1)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, synchronous, active-high
load_valid_i  input  1  load request
load_ready_o  output  1  load can be accepted this cycle
load_value_i  input  W  start value; period = load_value_i+1 enabled ticks
load_autoreload_i  input  1  sampled with load: 1 = periodic, 0 = one-shot
en_i  input  1  count enable (tick)
abort_i  input  1  synchronous abort to IDLE
ack_i  input  1  clears DONE
count_o  output  W  current count
busy_o  output  1  state == RUN
done_o  output  1  state == DONE
expire_o  output  1  registered one-cycle expiry pulse

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high: rst_i sampled high at a rising edge of clk_i resets the block.
- Reset values:
  - state = IDLE
  - count_o = 0, reload register = 0, autoreload flag = 0
  - expire_o = 0, busy_o = 0, done_o = 0
  - load_ready_o = 1
- Priority per cycle: rst_i > abort_i > load > ack_i/en_i.
- load_ready_o = 1 in IDLE and DONE, 0 in RUN. Loads are never accepted while running.
- Load handshake completes when load_valid_i && load_ready_o. On the next edge:
  - count_o <= load_value_i
  - reload register <= load_value_i
  - autoreload flag <= load_autoreload_i
  - state <= RUN
- en_i in the load cycle is ignored.
- States:
  - IDLE: waits for a load. en_i and ack_i are ignored.
  - RUN, en_i = 1, count_o != 0: count_o <= count_o-1.
  - RUN, en_i = 1, count_o == 0: expire_o <= 1 next cycle. Then:
    - autoreload = 1: count_o <= reload register, stay in RUN.
    - autoreload = 0: state <= DONE, count_o stays 0.
  - RUN, en_i = 0: hold everything.
  - DONE: done_o = 1, load_ready_o = 1.
    - ack_i -> IDLE.
    - A load in the same cycle as ack_i wins: -> RUN with the new value.
- expire_o is high for exactly one cycle per terminal tick. It is never asserted by load, abort or reset.
- Expiry spacing in auto-reload with en_i held high: exactly load_value+1 cycles, with no gap cycle at reload.
- abort_i in any state: next cycle state = IDLE, count_o = 0, autoreload flag = 0, expire_o = 0. A terminal tick in the abort cycle is discarded.
- Boundary cases:
  - load_value = 0: expires on the first enabled tick (period 1). In auto-reload it expires on every enabled tick.
  - load_value = 2^W-1: full-range period 2^W. No wrap below zero; count_o never underflows.
  - rst_i mid-RUN, with or without en_i: reset values next cycle, no expire.
- count_o is a direct register output. All outputs are glitch-free registered or state-decoded.

Test Plan:
- Reset check: assert rst_i 2 cycles with random inputs -> count_o=0, busy_o=0, done_o=0, expire_o=0, load_ready_o=1.
- One-shot run: load 3 (autoreload=0), en_i held high.
  - count_o = 3,2,1,0.
  - expire_o pulses one cycle after the 4th enabled tick; done_o=1 from the same cycle, count_o=0.
  - ack_i -> IDLE, load_ready_o stays 1.
- Periodic run: load 2 (autoreload=1), en_i high for 9 cycles -> count_o = 2,1,0,2,1,0,2,1,0; exactly 3 expire_o pulses, 3 cycles apart; busy_o stays 1.
- Gapped enable: load 1, en_i pattern 1,0,0,1 -> count_o = 1,0,0,0, then expire_o after the 2nd enabled tick only. Also: load 0, single tick -> immediate expire.
- Abort: load 10, run to count_o=5, assert abort_i with en_i=1 -> next cycle IDLE, count_o=0, no expire_o. A following load while in RUN is blocked (load_ready_o=0).
- Simultaneous events:
  - In DONE, load_valid_i=1 (value 4) and ack_i=1 together -> RUN with count_o=4.
  - rst_i with en_i=1 at count_o=0 in RUN -> no expire_o, reset values.

Source files
------------

// File: rtl/modn_down_timer.sv
// Loadable down-counting timer with one-shot and auto-reload modes.
// A period value is accepted through a valid/ready load port; the count
// decrements on enabled ticks and a one-cycle expiry pulse follows the
// enabled tick taken at zero. All outputs are driven straight from registers.
module modn_down_timer #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_valid_i,
    output logic         load_ready_o,
    input  logic [W-1:0] load_value_i,
    input  logic         load_autoreload_i,
    input  logic         en_i,
    input  logic         abort_i,
    input  logic         ack_i,
    output logic [W-1:0] count_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         expire_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       r_state;
    logic [W-1:0] r_count;
    logic [W-1:0] r_reload;
    logic         r_autoreload;
    logic         r_expire;
    logic         r_busy;
    logic         r_done;
    logic         r_ready;

    logic         w_load_fire;
    logic         w_count_zero;

    // Decode the load handshake and the terminal-count condition.
    always_comb begin
        w_load_fire  = load_valid_i & r_ready;
        w_count_zero = (r_count == {W{1'b0}});
    end

    // Timer state machine; status flags are registered alongside the state
    // so that busy/done/ready always agree with the state they describe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_count      <= {W{1'b0}};
            r_reload     <= {W{1'b0}};
            r_autoreload <= 1'b0;
            r_expire     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ready      <= 1'b1;
        end else begin
            // The expiry pulse lasts one cycle unless a terminal tick re-arms it.
            r_expire <= 1'b0;
            if (abort_i) begin
                // Abort discards any terminal tick taken in the same cycle.
                r_state      <= ST_IDLE;
                r_count      <= {W{1'b0}};
                r_autoreload <= 1'b0;
                r_busy       <= 1'b0;
                r_done       <= 1'b0;
                r_ready      <= 1'b1;
            end else if (w_load_fire) begin
                // A load beats ack in DONE; en_i in the load cycle is ignored.
                r_state      <= ST_RUN;
                r_count      <= load_value_i;
                r_reload     <= load_value_i;
                r_autoreload <= load_autoreload_i;
                r_busy       <= 1'b1;
                r_done       <= 1'b0;
                r_ready      <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_IDLE;
                    end
                    ST_RUN: begin
                        if (en_i) begin
                            if (!w_count_zero) begin
                                r_count <= r_count - W'(1);
                            end else begin
                                r_expire <= 1'b1;
                                if (r_autoreload) begin
                                    // Reload straight away: no gap cycle between periods.
                                    r_count <= r_reload;
                                end else begin
                                    r_state <= ST_DONE;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                    r_ready <= 1'b1;
                                end
                            end
                        end else begin
                            r_count <= r_count;
                        end
                    end
                    ST_DONE: begin
                        if (ack_i) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b0;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                    default: begin
                        r_state      <= ST_IDLE;
                        r_count      <= {W{1'b0}};
                        r_autoreload <= 1'b0;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b0;
                        r_ready      <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign count_o      = r_count;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign load_ready_o = r_ready;
    assign expire_o     = r_expire;

endmodule
